// File: rtl/spacecraft_ft_pkg.sv
// Shared constants for the three-level fault-tolerance mission sequencer:
// FSM encodings, status codes, default level masks and unit bit positions.
package spacecraft_ft_pkg;

    typedef logic [4:0] unit_mask_t;

    localparam int unsigned NUM_UNITS = 5;

    // Unit 1 is the MSB of every mask.
    localparam int unsigned UNIT1_IDX = 4;
    localparam int unsigned UNIT2_IDX = 3;
    localparam int unsigned UNIT3_IDX = 2;
    localparam int unsigned UNIT4_IDX = 1;
    localparam int unsigned UNIT5_IDX = 0;

    localparam unit_mask_t DEF_L1_MASK      = 5'b11110;
    localparam unit_mask_t DEF_L2_MASK      = 5'b11100;
    localparam unit_mask_t DEF_L3_MASK      = 5'b11000;
    localparam unit_mask_t DEF_L2_OFF_ALLOW = 5'b00010;
    localparam unit_mask_t DEF_L3_OFF_ALLOW = 5'b00110;

    localparam int unsigned DEF_SETTLE_CYC  = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 32;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_L1_CHK  = 4'd1;
    localparam logic [3:0] S_L2_ARM  = 4'd2;
    localparam logic [3:0] S_L2_CHK  = 4'd3;
    localparam logic [3:0] S_L3_ARM  = 4'd4;
    localparam logic [3:0] S_L3_CHK  = 4'd5;
    localparam logic [3:0] S_SUCCESS = 4'd6;
    localparam logic [3:0] S_ABORT   = 4'd7;
    localparam logic [3:0] S_FAIL    = 4'd8;

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_OK    = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;
    localparam logic [1:0] ST_FAIL  = 2'b11;

    function automatic logic is_check_state(input logic [3:0] s);
        return (s == S_L1_CHK) || (s == S_L2_CHK) || (s == S_L3_CHK);
    endfunction

    function automatic logic is_busy_state(input logic [3:0] s);
        return (s != S_IDLE) && (s != S_SUCCESS) && (s != S_ABORT) && (s != S_FAIL);
    endfunction

    function automatic logic is_terminal_state(input logic [3:0] s);
        return (s == S_SUCCESS) || (s == S_ABORT) || (s == S_FAIL);
    endfunction

endpackage

// File: rtl/level_check_timer.sv
// Settle and timeout counters shared by all three check levels; both clear while
// i_clr is high and saturate so they never wrap within a level.
module level_check_timer #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_healthy_ok,
    output logic o_pass,
    output logic o_tmo
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYC);

    logic [SW-1:0] r_settle;
    logic [SW-1:0] w_settle_d;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_d;

    always_comb begin
        w_settle_d = r_settle;
        w_tmo_d    = r_tmo;
        if (i_clr) begin
            w_settle_d = '0;
            w_tmo_d    = '0;
        end else begin
            if (!i_healthy_ok) begin
                w_settle_d = '0;
            end else if (r_settle != SETTLE_MAX) begin
                w_settle_d = r_settle + 1'b1;
            end
            if (r_tmo != TMO_MAX) begin
                w_tmo_d = r_tmo + 1'b1;
            end
        end
    end

    // Flags fire in the cycle the count is reached, so the FSM leaves on that edge.
    assign o_pass = !i_clr && i_healthy_ok && (w_settle_d == SETTLE_MAX);
    assign o_tmo  = !i_clr && (w_tmo_d == TMO_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= '0;
            r_tmo    <= '0;
        end else begin
            r_settle <= w_settle_d;
            r_tmo    <= w_tmo_d;
        end
    end

endmodule

// File: rtl/mission_level_sequencer.sv
// Mission sequencer: L1 check, arm L2, L2 check, arm L3, L3 check, with a sticky
// user-shutdown latch filtered per level and registered datapath controls.
module mission_level_sequencer
    import spacecraft_ft_pkg::*;
#(
    parameter logic [4:0]  L1_MASK      = DEF_L1_MASK,
    parameter logic [4:0]  L2_MASK      = DEF_L2_MASK,
    parameter logic [4:0]  L3_MASK      = DEF_L3_MASK,
    parameter logic [4:0]  L2_OFF_ALLOW = DEF_L2_OFF_ALLOW,
    parameter logic [4:0]  L3_OFF_ALLOW = DEF_L3_OFF_ALLOW,
    parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_abort_req,
    input  logic [4:0] i_health,
    input  logic [4:0] i_off_req,
    output logic [4:0] o_unit_en,
    output logic       o_sw_l2,
    output logic       o_sw_l3,
    output logic [2:0] o_level_passed,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_status
);

    logic [3:0] r_state;
    logic [3:0] w_state_d;
    logic [4:0] r_off_lat;
    logic [4:0] w_off_lat_nx;
    logic [4:0] w_off_lat_d;
    logic [4:0] r_unit_en;
    logic [4:0] w_unit_en_d;
    logic       r_sw_l2;
    logic       w_sw_l2_d;
    logic       r_sw_l3;
    logic       w_sw_l3_d;
    logic [2:0] r_level_passed;
    logic [2:0] w_lp_d;
    logic [1:0] r_status;
    logic [1:0] w_status_d;
    logic       r_busy;
    logic       r_done;

    logic [4:0] w_mask;
    logic [4:0] w_allow;
    logic [4:0] w_req;
    logic       w_in_chk;
    logic       w_start_ok;
    logic       w_healthy_ok;
    logic       w_pass;
    logic       w_tmo;

    always_comb begin
        w_mask  = '0;
        w_allow = '0;
        case (r_state)
            S_L1_CHK: w_mask = L1_MASK;
            S_L2_CHK: begin
                w_mask  = L2_MASK;
                w_allow = L2_OFF_ALLOW;
            end
            S_L3_CHK: begin
                w_mask  = L3_MASK;
                w_allow = L3_OFF_ALLOW;
            end
            default: ;
        endcase
    end

    assign w_in_chk     = is_check_state(r_state);
    assign w_start_ok   = (r_state == S_IDLE) && i_start;
    assign w_off_lat_nx = r_off_lat | (i_off_req & w_allow);
    assign w_req        = w_mask & ~w_off_lat_nx;
    assign w_healthy_ok = (i_health & w_req) == w_req;

    level_check_timer #(
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (!w_in_chk),
        .i_healthy_ok (w_healthy_ok),
        .o_pass       (w_pass),
        .o_tmo        (w_tmo)
    );

    // Abort beats pass, pass beats timeout.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_d = S_L1_CHK;
            S_L1_CHK: begin
                if (i_abort_req)  w_state_d = S_ABORT;
                else if (w_pass)  w_state_d = S_L2_ARM;
                else if (w_tmo)   w_state_d = S_ABORT;
            end
            S_L2_ARM: w_state_d = i_abort_req ? S_ABORT : S_L2_CHK;
            S_L2_CHK: begin
                if (i_abort_req)  w_state_d = S_ABORT;
                else if (w_pass)  w_state_d = S_L3_ARM;
                else if (w_tmo)   w_state_d = S_ABORT;
            end
            S_L3_ARM: w_state_d = i_abort_req ? S_ABORT : S_L3_CHK;
            S_L3_CHK: begin
                if (i_abort_req)  w_state_d = S_ABORT;
                else if (w_pass)  w_state_d = S_SUCCESS;
                else if (w_tmo)   w_state_d = S_FAIL;
            end
            S_SUCCESS, S_ABORT, S_FAIL: w_state_d = S_IDLE;
            default:  w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_off_lat_d = w_start_ok ? 5'b00000 : w_off_lat_nx;
        w_unit_en_d = r_unit_en;
        w_sw_l2_d   = r_sw_l2;
        w_sw_l3_d   = r_sw_l3;
        w_lp_d      = r_level_passed;
        w_status_d  = r_status;
        if (w_start_ok) begin
            w_lp_d     = '0;
            w_status_d = ST_NONE;
        end
        // ARM states are only ever entered from the preceding level's pass.
        case (w_state_d)
            S_IDLE: begin
                w_unit_en_d = '0;
                w_sw_l2_d   = 1'b0;
                w_sw_l3_d   = 1'b0;
            end
            S_L1_CHK: w_unit_en_d = L1_MASK & ~w_off_lat_d;
            S_L2_ARM: begin
                w_unit_en_d = L2_MASK;
                w_sw_l2_d   = 1'b1;
                w_lp_d[0]   = 1'b1;
            end
            S_L2_CHK: w_unit_en_d = L2_MASK & ~w_off_lat_d;
            S_L3_ARM: begin
                w_unit_en_d = L3_MASK;
                w_sw_l3_d   = 1'b1;
                w_lp_d[1]   = 1'b1;
            end
            S_L3_CHK: w_unit_en_d = L3_MASK & ~w_off_lat_d;
            S_SUCCESS: begin
                w_lp_d[2]  = 1'b1;
                w_status_d = ST_OK;
            end
            S_ABORT:  w_status_d = ST_ABORT;
            S_FAIL:   w_status_d = ST_FAIL;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_off_lat      <= '0;
            r_unit_en      <= '0;
            r_sw_l2        <= 1'b0;
            r_sw_l3        <= 1'b0;
            r_level_passed <= '0;
            r_status       <= ST_NONE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_off_lat      <= w_off_lat_d;
            r_unit_en      <= w_unit_en_d;
            r_sw_l2        <= w_sw_l2_d;
            r_sw_l3        <= w_sw_l3_d;
            r_level_passed <= w_lp_d;
            r_status       <= w_status_d;
            r_busy         <= is_busy_state(w_state_d);
            r_done         <= is_terminal_state(w_state_d);
        end
    end

    assign o_unit_en      = r_unit_en;
    assign o_sw_l2        = r_sw_l2;
    assign o_sw_l3        = r_sw_l3;
    assign o_level_passed = r_level_passed;
    assign o_status       = r_status;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_mission_level_sequencer.sv
// Directed bench for mission_level_sequencer: each mission pushes its expected
// result to a scoreboard queue, popped and compared when done pulses.
module tb_mission_level_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort_req = 1'b0;
    logic [4:0] health = 5'b00000;
    logic [4:0] off_req = 5'b00000;
    logic [4:0] unit_en;
    logic       sw_l2;
    logic       sw_l3;
    logic [2:0] level_passed;
    logic       busy;
    logic       done;
    logic [1:0] status;

    always #5 clk = ~clk;

    mission_level_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_abort_req    (abort_req),
        .i_health       (health),
        .i_off_req      (off_req),
        .o_unit_en      (unit_en),
        .o_sw_l2        (sw_l2),
        .o_sw_l3        (sw_l3),
        .o_level_passed (level_passed),
        .o_busy         (busy),
        .o_done         (done),
        .o_status       (status)
    );

    // done_rel/sw*_rel: cycles after the start cycle (start cycle = 0); -1 = never.
    typedef struct {
        logic [1:0] status;
        logic [2:0] lp;
        int         done_rel;
        int         sw2_rel;
        int         sw3_rel;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mission(input string name, input logic [4:0] h_l1, input logic [4:0] h_l2,
                               input logic [4:0] h_l3, input logic [4:0] off, input bit toggle,
                               input int abort_rel, input int start_rel, input int budget,
                               input exp_t e);
        int   sw2_seen = -1;
        int   sw3_seen = -1;
        int   done_rel = -1;
        exp_t x = e;
        health  = h_l1;
        off_req = off;
        start   = 1'b1;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
        check({name, "_l1_unit_en"}, unit_en, 5'b11110);
        for (int k = 1; k <= budget; k++) begin
            if (done) begin
                done_rel = k;
                x = sb_q.pop_front();
                break;
            end
            check({name, "_busy"}, busy, 1);
            if (sw_l2 && sw2_seen < 0) begin
                sw2_seen = k;
                health   = h_l2;
                check({name, "_l2_arm_unit_en"}, unit_en, 5'b11100);
            end
            if (sw_l3 && sw3_seen < 0) begin
                sw3_seen = k;
                health   = h_l3;
                check({name, "_l3_arm_unit_en"}, unit_en, 5'b11000);
            end
            if (sw2_seen > 0 && (k == sw2_seen + 1 || k == sw2_seen + 2) && sw3_seen < 0)
                check({name, "_l2_chk_unit_en"}, unit_en, 5'b11100);
            if (sw3_seen > 0 && k == sw3_seen + 1)
                check({name, "_l3_chk_unit_en"}, unit_en, 5'b11000);
            if (toggle && sw2_seen < 0) health[1] = ((k / 3) % 2 == 0);
            abort_req = (k == abort_rel);
            start     = (k == start_rel);
            tick();
        end
        abort_req = 1'b0;
        start     = 1'b0;
        check({name, "_done_seen"}, done_rel > 0, 1);
        check({name, "_done_cycle"}, done_rel, x.done_rel);
        check({name, "_status"}, status, x.status);
        check({name, "_level_passed"}, level_passed, x.lp);
        check({name, "_sw_l2_rise"}, sw2_seen, x.sw2_rel);
        check({name, "_sw_l3_rise"}, sw3_seen, x.sw3_rel);
        check({name, "_busy_at_done"}, busy, 0);
        tick();
        check({name, "_done_width"}, done, 0);
        check({name, "_idle_unit_en"}, unit_en, 0);
        check({name, "_idle_sw"}, {sw_l2, sw_l3}, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_held_status"}, status, x.status);
        check({name, "_held_lp"}, level_passed, x.lp);
        health  = 5'b11111;
        off_req = 5'b00000;
    endtask

    initial begin
        int   seen;
        int   dones;
        exp_t e;

        #1 rst = 1'b1;
        #2;
        check("rst_unit_en", unit_en, 0);
        check("rst_sw", {sw_l2, sw_l3}, 0);
        check("rst_level_passed", level_passed, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // All healthy; a stray start during L1 must be ignored.
        e = '{status: 2'b01, lp: 3'b111, done_rel: 15, sw2_rel: 5, sw3_rel: 10};
        run_mission("success", 5'b11111, 5'b11111, 5'b11111, 5'b00000, 0, -1, 3, 40, e);

        // Unit 4 unhealthy: L1 never settles.
        e = '{status: 2'b10, lp: 3'b000, done_rel: 33, sw2_rel: -1, sw3_rel: -1};
        run_mission("l1_tmo", 5'b11100, 5'b11100, 5'b11100, 5'b00000, 0, -1, -1, 60, e);

        // Unit 4 switched off by the user in L2, only units 1-2 healthy in L3.
        e = '{status: 2'b01, lp: 3'b111, done_rel: 15, sw2_rel: 5, sw3_rel: 10};
        run_mission("l2_off", 5'b11111, 5'b11100, 5'b11000, 5'b00010, 0, -1, -1, 40, e);

        // Unit 2 fails during L3.
        e = '{status: 2'b11, lp: 3'b011, done_rel: 43, sw2_rel: 5, sw3_rel: 10};
        run_mission("l3_fail", 5'b11111, 5'b11111, 5'b10111, 5'b00000, 0, -1, -1, 60, e);

        // Unit 4 flickers every 3 cycles: never 4 consecutive healthy cycles.
        e = '{status: 2'b10, lp: 3'b000, done_rel: 33, sw2_rel: -1, sw3_rel: -1};
        run_mission("toggle", 5'b11111, 5'b11111, 5'b11111, 5'b00000, 1, -1, -1, 60, e);

        // Abort coincides with the 4th healthy L2 cycle; start while busy ignored.
        e = '{status: 2'b10, lp: 3'b001, done_rel: 10, sw2_rel: 5, sw3_rel: -1};
        run_mission("abort_l2", 5'b11111, 5'b11111, 5'b11111, 5'b00000, 0, 9, 7, 40, e);

        // Reset in the middle of L3.
        health = 5'b11111;
        start  = 1'b1;
        tick();
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (sw_l3) seen = 1;
            else tick();
        end
        check("rst_mid_reached_l3", seen, 1);
        tick();
        tick();
        check("rst_mid_pre_lp", level_passed, 3'b011);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_unit_en", unit_en, 0);
        check("rst_mid_sw", {sw_l2, sw_l3}, 0);
        check("rst_mid_lp", level_passed, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        check("rst_mid_edge_outs", {unit_en, sw_l2, sw_l3, level_passed, busy, done, status}, 0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dones++;
        end
        check("rst_mid_no_done", dones, 0);
        check("rst_mid_idle_busy", busy, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
